// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared BTB geometry, counter encodings and entry layout
package bp_pkg;

  localparam int BP_ENTRIES = 16;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = 32 - BP_IDX_W - 2;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [31:0]         target;
    ctr_t                ctr;
  } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - 2-bit saturating counter next-state
module bp_sat_counter
  import bp_pkg::*;
(
  input  ctr_t i_ctr,
  input  logic i_taken,
  output ctr_t o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken && (i_ctr != ST)) begin
      o_ctr = i_ctr + 2'd1;
    end else if (!i_taken && (i_ctr != SNT)) begin
      o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, EX resolution and stats
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int IDX_W   = BP_IDX_W,
  parameter int TAG_W   = BP_TAG_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [31:0] next_pc,
  input  logic        ex_valid,
  input  logic        ex_kill,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        hit,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  btb_entry_t r_btb [ENTRIES];
  logic [31:0] r_br_count;
  logic [31:0] r_mp_count;

  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic [TAG_W-1:0] w_ex_tag;
  btb_entry_t       w_if_ent;
  btb_entry_t       w_ex_ent;
  logic             w_lhit;
  logic             w_pred_taken;
  logic             w_res;
  logic             w_mis;
  logic             w_ex_match;
  ctr_t             w_ctr_next;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[31:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[31:IDX_W+2];
  assign w_if_ent = r_btb[w_if_idx];
  assign w_ex_ent = r_btb[w_ex_idx];

  // Lookup reads registered state only, so a same-cycle update to this index is not bypassed.
  assign w_lhit       = w_if_ent.valid && (w_if_ent.tag == w_if_tag);
  assign w_pred_taken = w_lhit && w_if_ent.ctr[1];
  assign pred_taken   = w_pred_taken;
  assign pred_target  = w_pred_taken ? w_if_ent.target : (if_pc + 32'd4);
  assign next_pc      = pred_target;

  // rst_n gating keeps hit/flush quiet while the table is held in reset.
  assign w_res = rst_n && ex_valid && !ex_kill;
  assign w_mis = (ex_taken != ex_pred_taken) ||
                 (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
  assign hit         = w_res && !w_mis;
  assign flush       = w_res && w_mis;
  assign redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
  assign br_count    = r_br_count;
  assign mp_count    = r_mp_count;

  assign w_ex_match = w_ex_ent.valid && (w_ex_ent.tag == w_ex_tag);

  bp_sat_counter u_sat_counter (
    .i_ctr   (w_ex_ent.ctr),
    .i_taken (ex_taken),
    .o_ctr   (w_ctr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, ctr: WNT};
      end
      r_br_count <= 32'd0;
      r_mp_count <= 32'd0;
    end else if (w_res) begin
      if (w_ex_match) begin
        r_btb[w_ex_idx].ctr <= w_ctr_next;
        if (ex_taken) begin
          r_btb[w_ex_idx].target <= ex_target;
        end
      end else if (ex_taken) begin
        // Taken miss allocates (or evicts an alias) straight into weakly-taken.
        r_btb[w_ex_idx] <= '{valid: 1'b1, tag: w_ex_tag, target: ex_target, ctr: WT};
      end
      r_br_count <= r_br_count + 32'd1;
      r_mp_count <= r_mp_count + {31'd0, w_mis};
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed-vector bench for branch_predictor
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] next_pc;
  logic        ex_valid;
  logic        ex_kill;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        hit;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int checks;
  int failures;

  branch_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .next_pc        (next_pc),
    .ex_valid       (ex_valid),
    .ex_kill        (ex_kill),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .hit            (hit),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mp_count       (mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    ex_kill  = 1'b0;
    #1;
  endtask

  task automatic set_ex(input logic k, input logic [31:0] pc, input logic t,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
    ex_valid       = 1'b1;
    ex_kill        = k;
    ex_pc          = pc;
    ex_taken       = t;
    ex_target      = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptg;
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input string tag,
                      input logic exp_taken, input logic [31:0] exp_npc);
    if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
    check({tag, "_npc"}, next_pc, exp_npc);
  endtask

  task automatic counts(input string tag, input int br, input int mp);
    check({tag, "_br"}, br_count, br);
    check({tag, "_mp"}, mp_count, mp);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    if_pc = 32'h100;
    ex_valid = 1'b0;
    ex_kill = 1'b0;
    ex_pc = 32'h0;
    ex_taken = 1'b0;
    ex_target = 32'h0;
    ex_pred_taken = 1'b0;
    ex_pred_target = 32'h0;

    // Held in reset: resolution outputs must stay low even with a mispredict presented
    repeat (2) @(posedge clk);
    #1;
    set_ex(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_hit", {31'd0, hit}, 32'd0);
    look(32'h100, "rst", 1'b0, 32'h104);
    ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    look(32'h100, "post_rst", 1'b0, 32'h104);
    counts("post_rst", 0, 0);

    // First taken branch: mispredict, allocate with ctr=WT
    @(posedge clk);
    #1;
    set_ex(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    check("alloc_flush", {31'd0, flush}, 32'd1);
    check("alloc_hit", {31'd0, hit}, 32'd0);
    check("alloc_redir", redirect_pc, 32'h80);
    tick();
    look(32'h100, "alloc", 1'b1, 32'h80);
    check("alloc_ptgt", pred_target, 32'h80);
    counts("alloc", 1, 1);

    // Two correct taken resolutions: ctr -> ST
    for (int i = 0; i < 2; i++) begin
      set_ex(1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      check("tk_hit", {31'd0, hit}, 32'd1);
      check("tk_flush", {31'd0, flush}, 32'd0);
      tick();
    end
    counts("tk", 3, 1);

    // Not-taken while predicted taken: ST -> WT, still predicts taken
    set_ex(1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    check("nt1_flush", {31'd0, flush}, 32'd1);
    check("nt1_redir", redirect_pc, 32'h104);
    tick();
    look(32'h100, "nt1", 1'b1, 32'h80);
    counts("nt1", 4, 2);

    // Second not-taken: WT -> WNT, prediction drops (proves first step landed on WT, not ST)
    set_ex(1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    check("nt2_flush", {31'd0, flush}, 32'd1);
    tick();
    look(32'h100, "nt2", 1'b0, 32'h104);
    counts("nt2", 5, 3);

    // Taken on matching entry: WNT -> WT
    set_ex(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    tick();
    look(32'h100, "wt", 1'b1, 32'h80);

    // Target mismatch, with same-index lookup in the same cycle seeing the old target
    if_pc = 32'h100;
    set_ex(1'b0, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    check("tm_flush", {31'd0, flush}, 32'd1);
    check("tm_redir", redirect_pc, 32'h90);
    check("tm_same_cycle_npc", next_pc, 32'h80);
    tick();
    look(32'h100, "tm", 1'b1, 32'h90);
    counts("tm", 7, 5);

    // Killed taken branch at an aliasing PC: no outputs, no allocation, no counts
    set_ex(1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
    check("kill_hit", {31'd0, hit}, 32'd0);
    check("kill_flush", {31'd0, flush}, 32'd0);
    tick();
    look(32'h100, "kill_100", 1'b1, 32'h90);
    look(32'h140, "kill_140", 1'b0, 32'h144);
    counts("kill", 7, 5);

    // Aliasing: 0x140 shares index 0 with 0x100 and evicts it
    set_ex(1'b0, 32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
    check("alias_flush", {31'd0, flush}, 32'd1);
    tick();
    look(32'h100, "alias_100", 1'b0, 32'h104);
    look(32'h140, "alias_140", 1'b1, 32'h300);
    counts("alias", 8, 6);

    // Not-taken miss: correct prediction, no allocation
    set_ex(1'b0, 32'h208, 1'b0, 32'h400, 1'b0, 32'h0);
    check("ntm_hit", {31'd0, hit}, 32'd1);
    tick();
    look(32'h208, "ntm", 1'b0, 32'h20c);
    counts("ntm", 9, 6);

    // Mid-run asynchronous reset clears table and counters immediately
    rst_n = 1'b0;
    #1;
    counts("mid_rst", 0, 0);
    look(32'h140, "mid_rst", 1'b0, 32'h144);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    look(32'h140, "after_rst", 1'b0, 32'h144);
    counts("after_rst", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- Each cycle it supplies the predicted next PC to IF.
- When a branch resolves in EX, it receives the outcome and target address, generates hit/flush, and updates the table.
- It is the initiator end of the hit/flush protocol that the EX stage's flush logic consumes.

Parameters:
- ENTRIES, 16, number of BTB entries (power of two)
- IDX_W, 4, log2(ENTRIES)
- TAG_W, 26, tag width = 32 - IDX_W - 2

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- if_pc  input  32  current fetch PC
- pred_taken  output  1  prediction for if_pc (carried down the pipeline by ID/EX)
- pred_target  output  32  predicted target (carried down the pipeline)
- next_pc  output  32  PC for next fetch when no flush
- ex_valid  input  1  conditional branch or jal present in EX this cycle
- ex_kill  input  1  EX instruction squashed by an older flush; suppresses resolution
- ex_pc  input  32  PC of resolving branch
- ex_taken  input  1  actual outcome
- ex_target  input  32  computed target address (pc + imm<<1)
- ex_pred_taken  input  1  prediction carried with the branch
- ex_pred_target  input  32  predicted target carried with the branch
- hit  output  1  resolved prediction correct
- flush  output  1  mispredict; IF/ID and ID/EX must be squashed
- redirect_pc  output  32  correct PC when flush=1
- br_count  output  32  resolved branch count
- mp_count  output  32  mispredict count

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. PCs are word aligned; bits [1:0] are ignored.
- Per-entry state: valid (1), tag (TAG_W), target (32), ctr (2).
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Reset (asynchronous, rst_n=0):
  - all valid=0, all ctr=01, targets/tags=0, br_count=0, mp_count=0.
  - While in reset: pred_taken=0, next_pc=if_pc+4, hit=0, flush=0.
- Lookup (combinational from registered state, zero latency):
  - lhit = valid[idx] & (tag[idx]==if_tag).
  - pred_taken = lhit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4; next_pc = pred_target.
- Resolution (combinational), with res = ex_valid & ~ex_kill:
  - mis = (ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)).
  - hit = res & ~mis; flush = res & mis; hit and flush are never both 1.
  - redirect_pc = ex_taken ? ex_target : ex_pc+4; its value is don't-care when flush=0.
- Update (rising edge, only when res=1):
  - Entry matches ex_pc: ctr saturating +1 if taken, -1 if not (11 stays 11, 00 stays 00); if taken, target <= ex_target.
  - Entry misses and taken: allocate/replace: valid=1, tag, target=ex_target, ctr=10.
  - Entry misses and not taken: no table change.
  - br_count += 1; mp_count += mis. Both counters wrap modulo 2^32.
- Simultaneous lookup and update to the same index: the lookup sees pre-update contents (no bypass). The new value is visible the next cycle.
- ex_kill=1 with ex_valid=1: no update, no count, hit=flush=0.
- Reset asserted mid-operation clears state immediately. The first edge after deassertion behaves as a fresh start.

Decomposition:
- Shared package bp_pkg:
  - counter encodings SNT/WNT/WT/ST
  - localparams for IDX_W/TAG_W derivation
  - ctr_t typedef (2-bit)
  - btb_entry_t struct (valid, tag, target, ctr)
- Sub-module bp_sat_counter: combinational next-ctr from (ctr, taken).
- The table array, lookup, resolution and statistics stay in branch_predictor.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, next_pc=0x104; br_count=0, mp_count=0.
- Resolve ex_pc=0x100, taken, ex_target=0x80, ex_pred_taken=0:
  - same cycle: flush=1, redirect_pc=0x80.
  - next cycle, if_pc=0x100: pred_taken=1, next_pc=0x80 (ctr=10).
- Two further taken resolutions at 0x100 -> ctr=11. Then one not-taken (ex_pred_taken=1): flush=1, redirect_pc=0x104, ctr=10, pred_taken remains 1.
- Aliasing: allocate 0x100, then resolve taken at 0x140 (same index for ENTRIES=16) -> entry replaced; lookup at 0x100 gives pred_taken=0.
- Target mismatch: ex_pred_taken=1, ex_pred_target=0x80, ex_taken=1, ex_target=0x90 -> flush=1, redirect_pc=0x90, stored target becomes 0x90.
- Boundary handling:
  - ex_valid=1 with ex_kill=1 -> hit=flush=0, no table change, counts unchanged.
  - Lookup and update to the same index in one cycle -> old prediction returned.
  - rst_n pulsed mid-sequence -> all entries invalid, counts 0.
